// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues to a 1-cycle imem, buffers {pc,inst} for decode.
// Latency 2 cycles fetch-to-decode; backpressure via deq_ready, issue stalls when the queue is full.
// Optional FETCH_QUEUE_STATS_EN macro adds saturating redirect/empty/full statistic counters.
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [31:0]                deq_inst,
  output logic [ADDR_W-1:0]          deq_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]                stat_redirects,
  output logic [31:0]                stat_empty_cycles,
  output logic [31:0]                stat_full_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight_valid;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [31:0]       inst_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count_q;

  logic             fire;
  logic             wr;
  logic [CNT_W:0]   occupancy;

  wire unused_redirect_lsbs = ^redirect_pc[1:0];

  // Slots held or reserved after this cycle's dequeue; never underflows since fire implies count >= 1.
  assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_valid) - (CNT_W+1)'(fire);

  assign deq_valid = (count_q != '0) & !redirect_valid;
  assign fire      = deq_valid & deq_ready;
  assign imem_req  = !rst & !redirect_valid & (occupancy < (CNT_W+1)'(DEPTH));
  assign wr        = inflight_valid & !redirect_valid;
  assign imem_addr = fetch_pc;
  assign deq_inst  = inst_mem[head];
  assign deq_pc    = pc_mem[head];
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc       <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
      head           <= '0;
      tail           <= '0;
      count_q        <= '0;
    end else if (redirect_valid) begin
      fetch_pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
      inflight_valid <= 1'b0;
      head           <= '0;
      tail           <= '0;
      count_q        <= '0;
    end else begin
      inflight_valid <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(4);
      end
      if (wr)
        tail <= tail + PTR_W'(1);
      if (fire)
        head <= head + PTR_W'(1);
      case ({wr, fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (wr) begin
      pc_mem[tail]   <= inflight_pc;
      inst_mem[tail] <= imem_rdata;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_redirects    <= '0;
      stat_empty_cycles <= '0;
      stat_full_cycles  <= '0;
    end else begin
      if (redirect_valid && stat_redirects != '1)
        stat_redirects <= stat_redirects + 32'd1;
      if (deq_ready && !deq_valid && !redirect_valid && stat_empty_cycles != '1)
        stat_empty_cycles <= stat_empty_cycles + 32'd1;
      if (count_q == CNT_W'(DEPTH) && stat_full_cycles != '1)
        stat_full_cycles <= stat_full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, RESET_PC=0x100); memory word n holds value n.
// Stats counters are checked when FETCH_QUEUE_STATS_EN is defined.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic [2:0]  count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_redirects;
  logic [31:0] stat_empty_cycles;
  logic [31:0] stat_full_cycles;
`endif

  int passed = 0;
  int total  = 0;

  fetch_queue #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_inst(deq_inst), .deq_pc(deq_pc), .count(count)
`ifdef FETCH_QUEUE_STATS_EN
    , .stat_redirects(stat_redirects), .stat_empty_cycles(stat_empty_cycles),
    .stat_full_cycles(stat_full_cycles)
`endif
  );

  always #5 clk = ~clk;

  // One-cycle-latency instruction memory: word n holds n.
  always @(posedge clk) imem_rdata <= {2'b00, imem_addr[31:2]};

  typedef struct {
    logic        rst;
    logic        rdv;
    logic [31:0] rpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        dv;
    logic [31:0] dpc;
    logic [31:0] dinst;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic add(input logic r, input logic rv, input logic [31:0] rp, input logic rd,
                     input logic rq, input logic [31:0] ad, input logic v,
                     input logic [31:0] pc, input logic [31:0] ins, input logic [2:0] c);
    vec_t t;
    t = '{r, rv, rp, rd, rq, ad, v, pc, ins, c};
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rp, input logic rd);
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rp; deq_ready = rd;
  endtask

  initial begin
    int lat;
    logic [31:0] exp_pc;

    //   rst rdv rpc           rdy  req addr          dv pc            inst          cnt
    add(1, 0, 32'h0,        1,   0, 32'h100,       0, 32'h0,        32'h0,        3'd0);
    add(0, 0, 32'h0,        1,   1, 32'h100,       0, 32'h0,        32'h0,        3'd0);
    add(0, 0, 32'h0,        1,   1, 32'h104,       0, 32'h0,        32'h0,        3'd0);
    add(0, 0, 32'h0,        1,   1, 32'h108,       1, 32'h100,      32'h40,       3'd1);
    add(0, 0, 32'h0,        1,   1, 32'h10c,       1, 32'h104,      32'h41,       3'd1);
    add(0, 0, 32'h0,        1,   1, 32'h110,       1, 32'h108,      32'h42,       3'd1);
    add(0, 0, 32'h0,        0,   1, 32'h114,       1, 32'h10c,      32'h43,       3'd1);
    add(0, 0, 32'h0,        0,   1, 32'h118,       1, 32'h10c,      32'h43,       3'd2);
    add(0, 0, 32'h0,        0,   0, 32'h11c,       1, 32'h10c,      32'h43,       3'd3);
    add(0, 0, 32'h0,        0,   0, 32'h11c,       1, 32'h10c,      32'h43,       3'd4);
    add(0, 0, 32'h0,        0,   0, 32'h11c,       1, 32'h10c,      32'h43,       3'd4);
    add(0, 0, 32'h0,        1,   1, 32'h11c,       1, 32'h10c,      32'h43,       3'd4);
    add(0, 0, 32'h0,        1,   1, 32'h120,       1, 32'h110,      32'h44,       3'd3);
    add(0, 1, 32'h2002,     1,   0, 32'h124,       0, 32'h0,        32'h0,        3'd3);
    add(0, 0, 32'h0,        1,   1, 32'h2000,      0, 32'h0,        32'h0,        3'd0);
    add(0, 0, 32'h0,        1,   1, 32'h2004,      0, 32'h0,        32'h0,        3'd0);
    add(0, 0, 32'h0,        1,   1, 32'h2008,      1, 32'h2000,     32'h800,      3'd1);
    add(0, 1, 32'hFFFFFFFD, 1,   0, 32'h200c,      0, 32'h0,        32'h0,        3'd1);
    add(0, 0, 32'h0,        1,   1, 32'hFFFFFFFC,  0, 32'h0,        32'h0,        3'd0);
    add(0, 0, 32'h0,        1,   1, 32'h0,         0, 32'h0,        32'h0,        3'd0);
    add(0, 0, 32'h0,        1,   1, 32'h4,         1, 32'hFFFFFFFC, 32'h3FFFFFFF, 3'd1);
    add(0, 0, 32'h0,        1,   1, 32'h8,         1, 32'h0,        32'h0,        3'd1);
    add(1, 1, 32'h5000,     1,   0, 32'hc,         0, 32'h0,        32'h0,        3'd1);
    add(0, 0, 32'h0,        1,   1, 32'h100,       0, 32'h0,        32'h0,        3'd0);
    add(0, 0, 32'h0,        1,   1, 32'h104,       0, 32'h0,        32'h0,        3'd0);
    add(0, 0, 32'h0,        1,   1, 32'h108,       1, 32'h100,      32'h40,       3'd1);

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; deq_ready = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rdv, vecs[i].rpc, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d imem_req", i),  imem_req,  vecs[i].req);
      chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("v%0d deq_valid", i), deq_valid, vecs[i].dv);
      chk($sformatf("v%0d count", i),     count,     vecs[i].cnt);
      if (vecs[i].dv) begin
        chk($sformatf("v%0d deq_pc", i),   deq_pc,   vecs[i].dpc);
        chk($sformatf("v%0d deq_inst", i), deq_inst, vecs[i].dinst);
      end
    end

    // Reset release: bounded wait for first delivery, then a bubble-free stream.
    drive(1, 0, 32'h0, 1);
    drive(0, 0, 32'h0, 1);
    #1;
    lat = 0;
    while (!deq_valid && lat < 10) begin
      @(negedge clk); #1;
      lat++;
    end
    chk("first delivery latency", lat, 2);
    exp_pc = 32'h100;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("stream%0d deq_valid", k), deq_valid, 1'b1);
      chk($sformatf("stream%0d deq_pc", k),    deq_pc,    exp_pc);
      chk($sformatf("stream%0d deq_inst", k),  deq_inst,  {2'b00, exp_pc[31:2]});
      exp_pc = exp_pc + 32'd4;
      @(negedge clk); #1;
    end

`ifdef FETCH_QUEUE_STATS_EN
    // Two redirects and five starved cycles (ready high, nothing to deliver).
    drive(1, 0, 32'h0,   1);
    drive(0, 0, 32'h0,   1);
    drive(0, 0, 32'h0,   1);
    drive(0, 1, 32'h300, 1);
    drive(0, 0, 32'h0,   1);
    drive(0, 0, 32'h0,   0);
    drive(0, 1, 32'h400, 0);
    drive(0, 0, 32'h0,   1);
    drive(0, 0, 32'h0,   1);
    drive(0, 0, 32'h0,   1);
    @(negedge clk); #1;
    chk("stat_redirects",    stat_redirects,    32'd2);
    chk("stat_empty_cycles", stat_empty_cycles, 32'd5);
    chk("stat_full_cycles",  stat_full_cycles,  32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupled instruction-fetch front end with a parametrised prefetch queue. Owns the fetch PC, issues sequential requests to a one-cycle-latency instruction SRAM, buffers returned instructions with their PCs, and delivers them to decode over a valid/ready handshake. A redirect from the branch-resolution stage flushes the queue and discards any in-flight response. Sits between the PC/instruction-memory pair and the fetch/decode pipeline register.

## Interface
Parameters:
- `ADDR_W`, 32: PC / instruction address width.
- `DEPTH`, 4: queue entries; a power of two, ≥ 2.
- `RESET_PC`, 0: fetch PC after reset; word aligned.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch issued this cycle.
- `imem_addr` out ADDR_W: fetch address; always equals `fetch_pc`.
- `imem_rdata` in 32: instruction for the address issued the previous cycle.
- `redirect_valid` in 1: flush and redirect this cycle.
- `redirect_pc` in ADDR_W: redirect target; bits [1:0] are ignored and treated as 0.
- `deq_valid` out 1: head entry available.
- `deq_ready` in 1: decode accepts the head; fire = `deq_valid & deq_ready`.
- `deq_inst` out 32: head instruction.
- `deq_pc` out ADDR_W: head PC.
- `count` out $clog2(DEPTH+1): entries currently held.

## Operation
- State:
  - `fetch_pc`.
  - One in-flight tag: `inflight_valid` plus `inflight_pc`.
  - Circular buffer of DEPTH {pc, inst} entries with head and tail pointers that wrap modulo DEPTH.
  - `count`.
- Issue rule: `imem_req = !rst & !redirect_valid & (count + inflight_valid - fire < DEPTH)`. Same-cycle dequeue frees a slot; an entry is never written without a reserved slot.
- On issue:
  - `inflight_valid ← 1`, `inflight_pc ← fetch_pc`.
  - `fetch_pc ← fetch_pc + 4`, modulo 2^ADDR_W; wrap-around is legal.
  - A cycle without issue sets `inflight_valid ← 0`.
- Response: if `inflight_valid` and not `redirect_valid`, write {`inflight_pc`, `imem_rdata`} at the tail and advance the tail.
- Dequeue: on fire, advance the head.
- `count` update:
  - +1 on a write.
  - −1 on a fire.
  - Unchanged when both happen in the same cycle.
- Redirect (highest priority):
  - `deq_valid` is forced to 0 combinationally, so no fire occurs.
  - Next edge: head = tail = 0, `count` = 0, `inflight_valid` = 0, `fetch_pc` = {`redirect_pc[ADDR_W-1:2]`, 2'b00}.
  - The response arriving in the redirect cycle is dropped.
- Empty: `deq_valid = 0`; `deq_inst` / `deq_pc` hold stale contents and are don't-care.
- Full: `count == DEPTH` implies `imem_req = 0` unless fire happens that cycle.
- Reset:
  - Same clearing as redirect, with `fetch_pc = RESET_PC`.
  - Reset overrides a simultaneous redirect.
  - Reset mid-stream discards all queued and in-flight data.

## Timing
- Reset values: `imem_req` 0 while `rst` is high; `deq_valid` 0; `count` 0; `imem_addr` = RESET_PC.
- First cycle after `rst` falls (cycle 0): `imem_req` = 1 with `imem_addr` = RESET_PC.
- Cycle 1: rdata is captured at the edge.
- Cycle 2: `deq_valid` = 1.
- Fetch-to-decode latency: 2 cycles.
- Redirect asserted in cycle R:
  - R+1: issue of the target.
  - R+3: target visible on `deq_*`.
- Throughput: one instruction per cycle in steady state with `deq_ready` held high, for any DEPTH ≥ 2.
- Combinational paths:
  - `deq_ready` → `imem_req`.
  - `redirect_valid` → `imem_req` and `deq_valid`.
- No other combinational input-to-output paths.

## Configuration
- `FETCH_QUEUE_STATS_EN` defined adds three outputs, each a 32-bit saturating counter cleared by `rst`:
  - `stat_redirects` (32): +1 per cycle with `redirect_valid`.
  - `stat_empty_cycles` (32): +1 per cycle with `deq_ready & !deq_valid & !redirect_valid`.
  - `stat_full_cycles` (32): +1 per cycle with `count == DEPTH`.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

## Test plan
- Reset release with RESET_PC=0x100, `deq_ready`=1, memory word n = n:
  - `imem_addr` = 0x100, 0x104, 0x108 … on consecutive cycles.
  - `deq_valid` rises 2 cycles after release.
  - `deq_pc`/`deq_inst` = 0x100/0x40, then 0x104/0x41 each cycle, no bubbles.
- DEPTH=4, `deq_ready`=0:
  - `count` climbs to 4, then `imem_req` = 0 and `imem_addr` holds at 0x110.
  - Raise `deq_ready`: 0x100 is dequeued and a new issue occurs in that same cycle; no entry is lost or duplicated.
- Redirect to 0x2002 while `count`=3 and a request is in flight:
  - Next cycle `count` = 0.
  - `imem_addr` = 0x2000.
  - First `deq_pc` = 0x2000, exactly 3 cycles after the redirect; no stale PC ever appears.
- Redirect asserted in the same cycle as a fire attempt with `deq_ready`=1: `deq_valid` = 0 that cycle and the head is not consumed.
- `fetch_pc` = 0xFFFFFFFC, ADDR_W=32: the next `imem_addr` is 0x00000000.
- With `FETCH_QUEUE_STATS_EN`, 2 redirects plus 5 starved cycles: `stat_redirects`=2, `stat_empty_cycles`=5.
